matmul_apb_slave: RTL and testbench

//  Parametrised APB slave front end of the matmul accelerator. Runs the APB

---
 rtl/matmul_pkg.sv | 39 +++
 rtl/matmul_apb_decode.sv | 64 ++++++
 rtl/matmul_apb_slave.sv | 170 +++++++++++++++++
 tb/tb_matmul_apb_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and field positions for the matmul APB front end.
package matmul_pkg;

    // APB address regions, paddr[11:10]
    typedef enum logic [1:0] {
        RGN_CTRL = 2'd0,
        RGN_A    = 2'd1,
        RGN_B    = 2'd2,
        RGN_SP   = 2'd3
    } region_t;

    typedef enum logic [2:0] {IDLE, ACC, WDONE, RCAP, RDONE} apb_state_t;

    // rows inside the CTRL region
    localparam int CTRL_ROW        = 0;
    localparam int STATUS_ROW      = 1;

    // CTRL / STATUS bit positions
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ERRCLR_BIT = 1;
    localparam int CTRL_MODE_LSB   = 2;
    localparam int CTRL_MODE_MSB   = 3;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

    // address field positions
    localparam int RANGE_LSB       = 12;
    localparam int REGION_MSB      = 11;
    localparam int REGION_LSB      = 10;
    localparam int TARGET_MSB      = 9;
    localparam int TARGET_LSB      = 8;
    localparam int ROW_MSB         = 7;

    // scratchpad k lives at back-end select 2+k
    function automatic logic [2:0] sp_sel(input logic [1:0] tgt);
        return 3'd2 + {1'b0, tgt};
    endfunction

endpackage

// File: rtl/matmul_apb_decode.sv
// Combinational address decode: region, back-end select, row and legality.
module matmul_apb_decode
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int AL         = $clog2(BUS_WIDTH / 8),
    localparam int RW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    input  logic                  busy,
    output region_t               region,
    output logic [2:0]            sel,
    output logic [RW-1:0]         row,
    output logic                  err
);

    localparam int RFW = ROW_MSB - AL + 1;

    logic [RFW-1:0] row_f;
    logic [1:0]     tgt;
    logic           hi_bad, misal, row_bad, tgt_bad, ctrl_bad;

    assign row_f = paddr[ROW_MSB:AL];
    assign tgt   = paddr[TARGET_MSB:TARGET_LSB];
    assign misal = |paddr[AL-1:0];

    generate
        if (ADDR_WIDTH > RANGE_LSB) begin : g_hi
            assign hi_bad = |paddr[ADDR_WIDTH-1:RANGE_LSB];
        end else begin : g_nohi
            assign hi_bad = 1'b0;
        end
    endgenerate

    // region decode and per-region legality
    always_comb begin
        region   = region_t'(paddr[REGION_MSB:REGION_LSB]);
        row      = row_f[RW-1:0];
        sel      = 3'd0;
        tgt_bad  = 1'b0;
        ctrl_bad = 1'b0;
        row_bad  = row_f >= RFW'(MAX_DIM);
        case (region)
            RGN_A:  sel = 3'd0;
            RGN_B:  sel = 3'd1;
            RGN_SP: begin
                sel     = sp_sel(tgt);
                tgt_bad = {1'b0, tgt} >= 3'(SP_NTARGETS);
            end
            default: begin
                // only CTRL and STATUS exist; STATUS is read-only
                ctrl_bad = (row_f > RFW'(STATUS_ROW)) ||
                           (pwrite && row_f == RFW'(STATUS_ROW));
            end
        endcase
        err = misal | hi_bad | row_bad | tgt_bad | ctrl_bad | (pwrite & busy);
    end

endmodule

// File: rtl/matmul_apb_slave.sv
// APB slave front end of the matmul accelerator.
// Optional: define MATMUL_APB_ERR_EN to report illegal accesses on pslverr
// and track them in STATUS.err_sticky; otherwise they are dropped silently.
module matmul_apb_slave
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 16,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int RW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [MAX_DIM-1:0]    pstrb,
    input  logic [BUS_WIDTH-1:0]  pwdata,
    input  logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pready,
    output logic                  pslverr,
    output logic [BUS_WIDTH-1:0]  prdata,
    input  logic                  busy,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [2:0]            mem_sel,
    output logic [RW-1:0]         mem_row,
    output logic [MAX_DIM-1:0]    mem_strb,
    output logic [BUS_WIDTH-1:0]  mem_wdata,
    input  logic [BUS_WIDTH-1:0]  mem_rdata,
    output logic                  start,
    output logic [1:0]            mode
);

    apb_state_t          state, nxt;
    region_t             dec_region, region_q;
    logic [2:0]          dec_sel, sel_q;
    logic [RW-1:0]       dec_row, row_q;
    logic                dec_err, err_q, write_q;
    logic                setup, access, load, ctrl_fire;
    logic                err_sticky, clr_q;
    logic [BUS_WIDTH-1:0] rd_val;

    matmul_apb_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SP_NTARGETS(SP_NTARGETS)
    ) u_dec (
        .paddr (paddr),
        .pwrite(pwrite),
        .busy  (busy),
        .region(dec_region),
        .sel   (dec_sel),
        .row   (dec_row),
        .err   (dec_err)
    );

    assign setup  = psel & ~penable;
    assign access = psel & penable;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // next state; load marks a setup phase accepted this cycle
    always_comb begin
        nxt  = state;
        load = 1'b0;
        case (state)
            IDLE: if (setup) begin
                nxt  = ACC;
                load = 1'b1;
            end
            ACC: begin
                if (!psel)        nxt = IDLE;
                else if (penable) nxt = write_q ? WDONE : RCAP;
            end
            RCAP: nxt = psel ? RDONE : IDLE;
            WDONE, RDONE: begin
                if (setup) begin
                    nxt  = ACC;
                    load = 1'b1;
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // hold the decoded request for the rest of the transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            region_q <= RGN_CTRL;
            sel_q    <= 3'd0;
            row_q    <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
        end else if (load) begin
            region_q <= dec_region;
            sel_q    <= dec_sel;
            row_q    <= dec_row;
            err_q    <= dec_err;
            write_q  <= pwrite;
        end
    end

    // back-end strobe: only legal array accesses; an all-zero strobe write is a no-op
    assign mem_req   = (state == ACC) & access & ~err_q & (region_q != RGN_CTRL) &
                       (~write_q | (|pstrb));
    assign mem_we    = mem_req & write_q;
    assign mem_sel   = sel_q;
    assign mem_row   = row_q;
    assign mem_strb  = pstrb;
    assign mem_wdata = pwdata;

    // a legal CTRL write always targets row 0; STATUS writes are errors
    assign ctrl_fire = (state == ACC) & access & write_q & ~err_q &
                       (region_q == RGN_CTRL) & pstrb[0];

    assign pready = psel & ((state == WDONE) | (state == RDONE));
`ifdef MATMUL_APB_ERR_EN
    assign pslverr = pready & err_q;
`else
    assign pslverr = 1'b0;
`endif

    // CTRL side effects land in the WDONE cycle; a new error beats a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode       <= 2'b00;
            start      <= 1'b0;
            clr_q      <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            start <= ctrl_fire & pwdata[CTRL_START_BIT];
            clr_q <= ctrl_fire & pwdata[CTRL_ERRCLR_BIT];
            if (ctrl_fire) mode <= pwdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
            if (pready & pslverr) err_sticky <= 1'b1;
            else if (clr_q)       err_sticky <= 1'b0;
        end
    end

    // read mux: array data, CTRL readback or STATUS; errored reads give zero
    always_comb begin
        rd_val = '0;
        if (!err_q) begin
            if (region_q != RGN_CTRL) begin
                rd_val = mem_rdata;
            end else if (row_q == RW'(CTRL_ROW)) begin
                rd_val[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
            end else begin
                rd_val[STATUS_BUSY_BIT] = busy;
                rd_val[STATUS_ERR_BIT]  = err_sticky;
            end
        end
    end

    // read data register, loaded in the capture cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      prdata <= '0;
        else if (state == RCAP && psel) prdata <= rd_val;
    end

endmodule

// File: tb/tb_matmul_apb_slave.sv
// Directed, table-driven bench for matmul_apb_slave (SP_NTARGETS=2).
module tb_matmul_apb_slave;

    localparam int DW = 16;
    localparam int BW = 64;
    localparam int AW = 16;
    localparam int NT = 2;
    localparam int NV = 14;
`ifdef MATMUL_APB_ERR_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk, rst, psel, penable, pwrite, busy;
    logic [3:0]    pstrb;
    logic [63:0]   pwdata, prdata, mem_wdata, mem_rdata;
    logic [15:0]   paddr;
    logic          pready, pslverr, mem_req, mem_we, start;
    logic [2:0]    mem_sel;
    logic [1:0]    mem_row, mode;
    logic [3:0]    mem_strb;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [3:0]  strb;
        logic        bsy;
        logic [63:0] mrd;
        logic        xerr;
        int          xwaits;
        int          xreq;
        logic [2:0]  xsel;
        logic [1:0]  xrow;
        logic [63:0] xrd;
    } vec_t;

    vec_t tbl [NV];

    matmul_apb_slave #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .SP_NTARGETS(NT)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .pwdata(pwdata), .paddr(paddr), .pready(pready),
        .pslverr(pslverr), .prdata(prdata), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_row(mem_row), .mem_strb(mem_strb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .start(start), .mode(mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (start) start_cnt++;

    function automatic vec_t mk(logic wr, logic [15:0] a, logic [63:0] d, logic [3:0] s,
                                logic b, logic [63:0] m, logic xe, int xw, int xq,
                                logic [2:0] xs, logic [1:0] xr, logic [63:0] xd);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.bsy = b; v.mrd = m;
        v.xerr = xe; v.xwaits = xw; v.xreq = xq; v.xsel = xs; v.xrow = xr; v.xrd = xd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // one APB transfer; records wait states, back-end activity and the response
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [63:0] d,
                        input logic [3:0] s, output logic [63:0] rd, output logic er,
                        output int waits, output int nreq, output int nwe,
                        output logic [2:0] sl, output logic [1:0] rw);
        bit done;
        rd = '0; er = 1'b0; waits = 0; nreq = 0; nwe = 0; sl = '0; rw = '0; done = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                if (mem_we) nwe++;
                sl = mem_sel;
                rw = mem_row;
            end
            if (pready) begin
                done = 1;
                rd   = prdata;
                er   = pslverr;
            end else begin
                waits++;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout addr=%h: got no pready, required pready within 20 cycles", a);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    logic [2:0]  sl;
    logic [1:0]  rw;
    int          w, nq, nw, s0;

    initial begin
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; busy = 1'b0;
        pstrb = '0; pwdata = '0; paddr = '0; mem_rdata = '0;

        tbl[0]  = mk(1, 16'h0410, 64'h0004_0003_0002_0001, 4'hF, 0, 64'h0, 0, 1, 1, 3'd0, 2'd2, 64'h0);
        tbl[1]  = mk(0, 16'h0D18, 64'h0, 4'h0, 0, 64'hDEAD_BEEF_0000_1234, 0, 2, 1, 3'd3, 2'd3, 64'hDEAD_BEEF_0000_1234);
        tbl[2]  = mk(1, 16'h0800, 64'h55, 4'hF, 1, 64'h0, 1, 1, 0, 3'd0, 2'd0, 64'h0);
        tbl[3]  = mk(0, 16'h0008, 64'h0, 4'h0, 1, 64'h0, 0, 2, 0, 3'd0, 2'd0, {62'b0, EE, 1'b1});
        tbl[4]  = mk(1, 16'h0000, 64'h2, 4'h1, 0, 64'h0, 0, 1, 0, 3'd0, 2'd0, 64'h0);
        tbl[5]  = mk(0, 16'h0008, 64'h0, 4'h0, 0, 64'h0, 0, 2, 0, 3'd0, 2'd0, 64'h0);
        tbl[6]  = mk(0, 16'h0F00, 64'h0, 4'h0, 0, 64'h1111, 1, 2, 0, 3'd0, 2'd0, 64'h0);
        tbl[7]  = mk(0, 16'h0404, 64'h0, 4'h0, 0, 64'h2222, 1, 2, 0, 3'd0, 2'd0, 64'h0);
        tbl[8]  = mk(1, 16'h0408, 64'h77, 4'h0, 0, 64'h0, 0, 1, 0, 3'd0, 2'd0, 64'h0);
        tbl[9]  = mk(1, 16'h0420, 64'h77, 4'hF, 0, 64'h0, 1, 1, 0, 3'd0, 2'd0, 64'h0);
        tbl[10] = mk(1, 16'h0008, 64'h3, 4'h1, 0, 64'h0, 1, 1, 0, 3'd0, 2'd0, 64'h0);
        tbl[11] = mk(0, 16'h1408, 64'h0, 4'h0, 0, 64'h3333, 1, 2, 0, 3'd0, 2'd0, 64'h0);
        tbl[12] = mk(0, 16'h0808, 64'h0, 4'h0, 0, 64'hAAAA, 0, 2, 1, 3'd1, 2'd1, 64'hAAAA);
        tbl[13] = mk(0, 16'h0008, 64'h0, 4'h0, 0, 64'h0, 0, 2, 0, 3'd0, 2'd0, {62'b0, EE, 1'b0});

        // reset state
        #12;
        chk("rst pready",  {63'b0, pready},  64'h0);
        chk("rst pslverr", {63'b0, pslverr}, 64'h0);
        chk("rst prdata",  prdata,           64'h0);
        chk("rst mem_req", {63'b0, mem_req}, 64'h0);
        chk("rst mem_we",  {63'b0, mem_we},  64'h0);
        chk("rst start",   {63'b0, start},   64'h0);
        chk("rst mode",    {62'b0, mode},    64'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            busy      = tbl[i].bsy;
            mem_rdata = tbl[i].mrd;
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rd, er, w, nq, nw, sl, rw);
            chk($sformatf("v%0d pslverr", i), {63'b0, er}, {63'b0, EE & tbl[i].xerr});
            chk($sformatf("v%0d waits", i), 64'(w), 64'(tbl[i].xwaits));
            chk($sformatf("v%0d mem_req", i), 64'(nq), 64'(tbl[i].xreq));
            chk($sformatf("v%0d mem_we", i), 64'(nw), tbl[i].wr ? 64'(tbl[i].xreq) : 64'h0);
            if (tbl[i].xreq != 0) begin
                chk($sformatf("v%0d mem_sel", i), {61'b0, sl}, {61'b0, tbl[i].xsel});
                chk($sformatf("v%0d mem_row", i), {62'b0, rw}, {62'b0, tbl[i].xrow});
            end
            if (!tbl[i].wr)
                chk($sformatf("v%0d prdata", i), rd, tbl[i].xrd);
        end

        // CTRL write 0x9: single start pulse, mode=2, readback 0x8
        busy = 1'b0;
        s0 = start_cnt;
        xfer(1, 16'h0000, 64'h9, 4'h1, rd, er, w, nq, nw, sl, rw);
        chk("ctrl9 pslverr", {63'b0, er}, 64'h0);
        @(negedge clk);
        chk("ctrl9 start pulses", 64'(start_cnt - s0), 64'h1);
        chk("ctrl9 mode", {62'b0, mode}, 64'h2);
        xfer(0, 16'h0000, 64'h0, 4'h0, rd, er, w, nq, nw, sl, rw);
        chk("ctrl readback", rd, 64'h8);

        // async reset while the read sits in the capture cycle
        mem_rdata = 64'h5555;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0808; pstrb = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst pready", {63'b0, pready}, 64'h0);
        chk("midrst prdata", prdata, 64'h0);
        chk("midrst mode", {62'b0, mode}, 64'h0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        xfer(0, 16'h0808, 64'h0, 4'h0, rd, er, w, nq, nw, sl, rw);
        chk("postrst waits", 64'(w), 64'h2);
        chk("postrst prdata", rd, 64'h5555);
        chk("postrst pslverr", {63'b0, er}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
